// File: rtl/rst_seq_pkg.sv
// Shared types and counter-width helpers for the rst_seq reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_SW  = 2'd1,
        CAUSE_EXT = 2'd2
    } cause_t;

    // Bits needed to hold 0..max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    // Bits needed to index count items.
    function automatic int idx_width(input int count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer whose flops are forced to PRESET while rst is high.
module rst_seq_sync2 #(
    parameter logic PRESET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: both flops use <= so q always takes the previous-cycle meta, giving two real stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= PRESET;
            q    <= PRESET;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Ordered reset-release sequencer: stretch all stage resets, then release one stage per ack.
// Define RST_SEQ_TIMEOUT_EN to build the per-stage ack timeout and sticky timeout_err flag.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int ACK_TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_sw,
    input  logic                  req_ext_n,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  busy,
    output logic [1:0]            rst_cause,
    output logic                  timeout_err
);

    localparam int STRETCH_W = cnt_width(STRETCH_CYCLES - 1);
    localparam int IDX_W     = idx_width(NUM_STAGES);
    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || STRETCH_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_cfg_err
        $error("rst_seq: parameter out of range");
    end

    state_t                state;
    cause_t                cause;
    logic [STRETCH_W-1:0]  stretch_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  ext_sync;
    logic                  ext_req;
    logic                  restart;
    logic                  ack_cur;
    logic                  wait_expired;
    logic                  advance;

    rst_seq_sync2 #(
        .PRESET (1'b1)
    ) u_ext_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_ext_n),
        .q   (ext_sync)
    );

    assign ext_req   = ~ext_sync;
    assign restart   = req_sw | ext_req;
    assign ack_cur   = stage_ack[idx];
    assign advance   = (state == ST_RELEASE) && (ack_cur || wait_expired);
    assign rst_cause = cause;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ASSERT;
            stretch_cnt <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
            busy        <= 1'b1;
            cause       <= CAUSE_POR;
        end else if (restart) begin
            // A held-low ext request lands here every cycle, pinning the stretch count at 0.
            state       <= ST_ASSERT;
            stretch_cnt <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
            busy        <= 1'b1;
            cause       <= ext_req ? CAUSE_EXT : CAUSE_SW;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (stretch_cnt == STRETCH_LAST) begin
                        state       <= ST_RELEASE;
                        stretch_cnt <= '0;
                        idx         <= '0;
                        stage_rst_n <= NUM_STAGES'(1);
                    end else begin
                        stretch_cnt <= stretch_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (advance) begin
                        if (idx == IDX_LAST) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx         <= idx + 1'b1;
                            stage_rst_n <= (stage_rst_n << 1) | NUM_STAGES'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    stage_rst_n <= '1;
                    busy        <= 1'b0;
                end
                default: state <= ST_ASSERT;
            endcase
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int WAIT_W = cnt_width(ACK_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign wait_expired = (wait_cnt == WAIT_LAST);

    // Counts cycles spent waiting on the current stage; a timeout advances like an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (restart || state != ST_RELEASE || advance) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (req_sw) begin
                timeout_err <= 1'b0;
            end else if (!restart && state == ST_RELEASE && !ack_cur && wait_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule
